// File: rtl/rtc_time_core.sv
// Time-of-day counter: hh:mm:ss held as 24-hour fields, seconds prescaler,
// validated load, 12/24-hour display mapping, minute-resolution alarm and
// one-cycle rollover strobes.
module rtc_time_core #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned DIV_W    = $clog2(TICK_DIV + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       mode_24,
  input  logic       set_valid,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic [5:0] set_ss,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       set_err,
  output logic       alarm_hit
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_ss;
  logic [5:0]       r_mm;
  logic [4:0]       r_hr;
  logic             r_sec_tick, r_min_tick, r_hour_tick, r_day_tick;
  logic             r_set_err, r_alarm_hit;

  logic [DIV_W-1:0] w_div_n;
  logic [5:0]       w_ss_n, w_mm_n;
  logic [4:0]       w_hr_n;
  logic             w_sec_n, w_min_n, w_hour_n, w_day_n, w_err_n, w_alarm_n;
  logic             w_tick, w_load_ok, w_ss_wrap, w_mm_wrap;
  logic [5:0]       w_ss_inc, w_mm_inc;
  logic [4:0]       w_hr_inc;

  // Successor time: every field advances on the same tick, no cascade lag
  always_comb begin
    w_tick    = en & (r_div == DIV_LAST);
    w_load_ok = (set_ss <= 6'd59) & (set_mm <= 6'd59) & (set_hh <= 5'd23);
    w_ss_wrap = (r_ss == 6'd59);
    w_mm_wrap = w_ss_wrap & (r_mm == 6'd59);
    w_ss_inc  = w_ss_wrap ? 6'd0 : r_ss + 6'd1;
    w_mm_inc  = w_ss_wrap ? ((r_mm == 6'd59) ? 6'd0 : r_mm + 6'd1) : r_mm;
    w_hr_inc  = w_mm_wrap ? ((r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1) : r_hr;
  end

  // Next-state: load beats tick; a rejected load freezes everything
  always_comb begin
    w_div_n   = r_div;
    w_ss_n    = r_ss;
    w_mm_n    = r_mm;
    w_hr_n    = r_hr;
    w_sec_n   = 1'b0;
    w_min_n   = 1'b0;
    w_hour_n  = 1'b0;
    w_day_n   = 1'b0;
    w_err_n   = 1'b0;
    w_alarm_n = 1'b0;
    if (set_valid) begin
      if (w_load_ok) begin
        w_ss_n  = set_ss;
        w_mm_n  = set_mm;
        w_hr_n  = set_hh;
        w_div_n = '0;
      end else begin
        w_err_n = 1'b1;
      end
    end else if (en) begin
      if (w_tick) begin
        w_div_n   = '0;
        w_ss_n    = w_ss_inc;
        w_mm_n    = w_mm_inc;
        w_hr_n    = w_hr_inc;
        w_sec_n   = 1'b1;
        w_min_n   = w_ss_wrap;
        w_hour_n  = w_mm_wrap;
        w_day_n   = w_mm_wrap & (r_hr == 5'd23);
        // out-of-range alarm fields can never equal an in-range successor
        w_alarm_n = alarm_en & (w_ss_inc == 6'd0) &
                    (w_mm_inc == alarm_mm) & (w_hr_inc == alarm_hh);
      end else begin
        w_div_n = r_div + DIV_W'(1);
      end
    end
  end

  // State and strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div       <= '0;
      r_ss        <= '0;
      r_mm        <= '0;
      r_hr        <= '0;
      r_sec_tick  <= 1'b0;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_set_err   <= 1'b0;
      r_alarm_hit <= 1'b0;
    end else begin
      r_div       <= w_div_n;
      r_ss        <= w_ss_n;
      r_mm        <= w_mm_n;
      r_hr        <= w_hr_n;
      r_sec_tick  <= w_sec_n;
      r_min_tick  <= w_min_n;
      r_hour_tick <= w_hour_n;
      r_day_tick  <= w_day_n;
      r_set_err   <= w_err_n;
      r_alarm_hit <= w_alarm_n;
    end
  end

  // Display hours follow mode_24 with no latency; stored time is untouched
  always_comb begin
    hours = r_hr;
    if (!mode_24) begin
      if (r_hr == 5'd0)       hours = 5'd12;
      else if (r_hr > 5'd12)  hours = r_hr - 5'd12;
      else                    hours = r_hr;
    end
  end

  assign pm        = (r_hr >= 5'd12);
  assign seconds   = r_ss;
  assign minutes   = r_mm;
  assign sec_tick  = r_sec_tick;
  assign min_tick  = r_min_tick;
  assign hour_tick = r_hour_tick;
  assign day_tick  = r_day_tick;
  assign set_err   = r_set_err;
  assign alarm_hit = r_alarm_hit;

endmodule

// File: tb/tb_rtc_time_core.sv
// Randomised and directed bench for rtc_time_core against a seconds-of-day model.
module tb_rtc_time_core;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, mode_24, set_valid, alarm_en;
  logic [4:0] set_hh, alarm_hh;
  logic [5:0] set_mm, set_ss, alarm_mm;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic       pm, sec_tick, min_tick, hour_tick, day_tick, set_err, alarm_hit;

  int n_checks = 0;
  int n_errors = 0;

  // model: time as seconds since midnight, prescaler count, expected strobes
  int m_t, m_p;
  bit e_sec, e_min, e_hour, e_day, e_err, e_alarm;

  rtc_time_core #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode_24(mode_24),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .seconds(seconds), .minutes(minutes), .hours(hours), .pm(pm),
    .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick),
    .day_tick(day_tick), .set_err(set_err), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_t = 0; m_p = 0;
    e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_err = 0; e_alarm = 0;
  endfunction

  function automatic void model_edge();
    int at;
    e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_err = 0; e_alarm = 0;
    if (set_valid) begin
      if (int'(set_hh) <= 23 && int'(set_mm) <= 59 && int'(set_ss) <= 59) begin
        m_t = int'(set_hh) * 3600 + int'(set_mm) * 60 + int'(set_ss);
        m_p = 0;
      end else begin
        e_err = 1;
      end
    end else if (en) begin
      if (m_p == int'(TICK_DIV) - 1) begin
        m_p    = 0;
        m_t    = (m_t + 1) % 86400;
        e_sec  = 1;
        e_min  = (m_t % 60 == 0);
        e_hour = (m_t % 3600 == 0);
        e_day  = (m_t == 0);
        at     = int'(alarm_hh) * 3600 + int'(alarm_mm) * 60;
        e_alarm = alarm_en && int'(alarm_hh) <= 23 && int'(alarm_mm) <= 59 && m_t == at;
      end else begin
        m_p++;
      end
    end
  endfunction

  task automatic compare_all();
    int h, hdisp;
    h     = m_t / 3600;
    hdisp = mode_24 ? h : ((h + 11) % 12) + 1;
    check_val("seconds", 32'(seconds), 32'(m_t % 60));
    check_val("minutes", 32'(minutes), 32'((m_t / 60) % 60));
    check_val("hours", 32'(hours), 32'(hdisp));
    check_val("pm", 32'(pm), 32'(h >= 12));
    check_val("sec_tick", 32'(sec_tick), 32'(e_sec));
    check_val("min_tick", 32'(min_tick), 32'(e_min));
    check_val("hour_tick", 32'(hour_tick), 32'(e_hour));
    check_val("day_tick", 32'(day_tick), 32'(e_day));
    check_val("set_err", 32'(set_err), 32'(e_err));
    check_val("alarm_hit", 32'(alarm_hit), 32'(e_alarm));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic load(input int hh, input int mm, input int ss);
    set_valid = 1'b1;
    set_hh = 5'(hh); set_mm = 6'(mm); set_ss = 6'(ss);
    cyc();
    set_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0; en = 1'b0; mode_24 = 1'b0; set_valid = 1'b0;
    set_hh = '0; set_mm = '0; set_ss = '0;
    alarm_en = 1'b0; alarm_hh = '0; alarm_mm = '0;
    model_reset();
    #1;
    compare_all();
    check_val("reset_hours12", 32'(hours), 32'd12);

    // free run from reset: one minute in 240 clocks
    @(negedge clk);
    reset_n = 1'b1; en = 1'b1; mode_24 = 1'b1;
    cnt = 0;
    repeat (240) begin
      cyc();
      if (min_tick) cnt++;
    end
    check_val("run_min_ticks", 32'(cnt), 32'd1);
    check_val("run_minutes", 32'(minutes), 32'd1);
    check_val("run_seconds", 32'(seconds), 32'd0);

    // midnight rollover with all strobes together
    mode_24 = 1'b0;
    load(23, 59, 58);
    repeat (8) cyc();
    check_val("mid_all_ticks", 32'({sec_tick, min_tick, hour_tick, day_tick}), 32'hF);
    check_val("mid_hours12", 32'(hours), 32'd12);
    check_val("mid_pm", 32'(pm), 32'd0);

    // display mode switch has zero latency
    en = 1'b0;
    load(13, 5, 0);
    check_val("mode12_hours", 32'(hours), 32'd1);
    check_val("mode12_pm", 32'(pm), 32'd1);
    mode_24 = 1'b1;
    #1;
    check_val("mode24_hours", 32'(hours), 32'd13);
    compare_all();

    // rejected loads and load-over-tick priority
    load(24, 0, 0);
    check_val("bad_hh_err", 32'(set_err), 32'd1);
    check_val("bad_hh_min", 32'(minutes), 32'd5);
    load(1, 60, 0);
    check_val("bad_mm_err", 32'(set_err), 32'd1);
    cyc();
    check_val("err_one_cycle", 32'(set_err), 32'd0);
    en = 1'b1;
    repeat (TICK_DIV) if (m_p != int'(TICK_DIV) - 1) cyc();
    load(2, 3, 4);
    check_val("prio_seconds", 32'(seconds), 32'd4);
    check_val("prio_sec_tick", 32'(sec_tick), 32'd0);

    // alarm
    alarm_hh = 5'd7; alarm_mm = 6'd30; alarm_en = 1'b1;
    load(7, 29, 59);
    cnt = 0;
    repeat (8) begin cyc(); if (alarm_hit) cnt++; end
    check_val("alarm_one_hit", 32'(cnt), 32'd1);
    alarm_en = 1'b0;
    load(7, 29, 59);
    cnt = 0;
    repeat (8) begin cyc(); if (alarm_hit) cnt++; end
    check_val("alarm_disabled", 32'(cnt), 32'd0);
    alarm_en = 1'b1;
    load(7, 30, 0);
    cnt = 0;
    repeat (3) begin cyc(); if (alarm_hit) cnt++; end
    check_val("alarm_on_load", 32'(cnt), 32'd0);

    // asynchronous reset mid-second
    load(10, 20, 30);
    cyc();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("async_seconds", 32'(seconds), 32'd0);
    check_val("async_minutes", 32'(minutes), 32'd0);
    check_val("async_hours", 32'(hours), 32'd0);
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // en low freezes time and strobes
    load(10, 20, 30);
    en = 1'b0;
    cnt = 0;
    repeat (50) begin cyc(); if (sec_tick | min_tick | hour_tick | day_tick) cnt++; end
    check_val("frozen_strobes", 32'(cnt), 32'd0);
    check_val("frozen_seconds", 32'(seconds), 32'd30);

    // randomised run
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) begin
        alarm_hh = 5'($urandom_range(0, 24));
        alarm_mm = 6'($urandom_range(1, 62));
        alarm_en = 1'($urandom_range(0, 3) != 0);
      end
      en      = 1'($urandom_range(0, 9) != 0);
      mode_24 = 1'($urandom_range(0, 1));
      set_valid = 1'($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) begin
        set_hh = alarm_hh; set_mm = alarm_mm - 6'd1; set_ss = 6'd59;
      end else begin
        set_hh = 5'($urandom_range(0, 25));
        set_mm = 6'($urandom_range(0, 61));
        set_ss = 6'($urandom_range(0, 61));
      end
      cyc();
    end
    set_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
